// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the D-stage hazard scheduler.
package hazard_pkg;

  localparam logic [1:0] TUSE_NONE  = 2'd3;

  // D-stage forward selects
  localparam logic [1:0] FWD_GRF    = 2'd0;
  localparam logic [1:0] FWD_E      = 2'd1;
  localparam logic [1:0] FWD_M      = 2'd2;

  // E-stage forward selects
  localparam logic [1:0] FWD_NONE   = 2'd0;
  localparam logic [1:0] FWD_FROM_M = 2'd1;
  localparam logic [1:0] FWD_FROM_W = 2'd2;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [4:0] a3;
    logic       we;
    logic [1:0] tnew;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // Tnew counts down toward 0 and holds there.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // $0 is hardwired, so it never creates a dependence.
  function automatic logic stage_match(input stage_t s, input logic [4:0] src);
    return s.we && (s.a3 == src) && (src != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// D-stage request fields, flush, and the scheduler's stall/forward controls.
interface hazard_scheduler_if;
  logic       req;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_Tuse_rs;
  logic [1:0] D_Tuse_rt;
  logic [4:0] D_A3;
  logic       D_RegWrite;
  logic [1:0] D_Tnew;
  logic       D_md_start;
  logic       D_md_div;
  logic       D_md_use;
  logic       stall;
  logic [1:0] D_fwd_rs;
  logic [1:0] D_fwd_rt;
  logic [1:0] E_fwd_rs;
  logic [1:0] E_fwd_rt;
  logic       md_busy;

  modport master (
    output req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_A3, D_RegWrite, D_Tnew,
           D_md_start, D_md_div, D_md_use,
    input  stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, md_busy
  );

  modport slave (
    input  req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_A3, D_RegWrite, D_Tnew,
           D_md_start, D_md_div, D_md_use,
    output stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, md_busy
  );
endinterface

// File: rtl/hazard_scheduler_md_busy_counter.sv
// Multiply/divide unit busy countdown. Loads on issue, otherwise counts down to 0.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] count;

  // Countdown register; an issuing MDU op reloads, exceptions do not cancel it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_scheduler.sv
// Stall/forward scheduler beside the D stage: tracks E/M/W producers and the MDU.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  hazard_scheduler_if.slave hif
);

  stage_t     e_stage;
  stage_t     m_stage;
  logic [4:0] e_rs;
  logic [4:0] e_rt;
  logic [4:0] w_a3;
  logic       w_we;

  logic       stall;
  logic       md_busy;
  logic       md_load;
  logic       rs_hazard;
  logic       rt_hazard;
  logic       md_hazard;

  // A source with Tnew still ahead of its Tuse in E or M cannot be satisfied yet.
  function automatic logic src_hazard(input stage_t e, input stage_t m,
                                      input logic [4:0] src, input logic [1:0] tuse);
    logic h;
    h = 1'b0;
    if (tuse != TUSE_NONE) begin
      if (stage_match(e, src) && (e.tnew > tuse)) h = 1'b1;
      if (stage_match(m, src) && (m.tnew > tuse)) h = 1'b1;
    end
    return h;
  endfunction

  // E is the nearest producer, so a pending E result shadows a ready M result.
  function automatic logic [1:0] d_fwd_sel(input stage_t e, input stage_t m,
                                           input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_GRF;
    if (stage_match(e, src)) begin
      if (e.tnew == 2'd0) sel = FWD_E;
    end else if (stage_match(m, src) && (m.tnew == 2'd0)) begin
      sel = FWD_M;
    end
    return sel;
  endfunction

  function automatic logic [1:0] e_fwd_sel(input stage_t m, input logic [4:0] w_a3_i,
                                           input logic w_we_i, input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (stage_match(m, src) && (m.tnew == 2'd0)) begin
      sel = FWD_FROM_M;
    end else if (w_we_i && (w_a3_i == src) && (src != 5'd0)) begin
      sel = FWD_FROM_W;
    end
    return sel;
  endfunction

  // Stall decision and forward selects from the registered trackers.
  always_comb begin
    rs_hazard = src_hazard(e_stage, m_stage, hif.D_rs, hif.D_Tuse_rs);
    rt_hazard = src_hazard(e_stage, m_stage, hif.D_rt, hif.D_Tuse_rt);
    md_hazard = (hif.D_md_start || hif.D_md_use) && md_busy;
    stall     = rs_hazard || rt_hazard || md_hazard;
    md_load   = hif.D_md_start && !stall && !hif.req;
  end

  // Pipeline trackers; flush and reset both empty E/M/W.
  always_ff @(posedge clk) begin
    if (!reset || hif.req) begin
      e_stage <= STAGE_BUBBLE;
      e_rs    <= 5'd0;
      e_rt    <= 5'd0;
      m_stage <= STAGE_BUBBLE;
      w_a3    <= 5'd0;
      w_we    <= 1'b0;
    end else begin
      if (stall) begin
        e_stage <= STAGE_BUBBLE;
        e_rs    <= 5'd0;
        e_rt    <= 5'd0;
      end else begin
        e_stage <= '{a3: hif.D_A3, we: hif.D_RegWrite, tnew: hif.D_Tnew};
        e_rs    <= hif.D_rs;
        e_rt    <= hif.D_rt;
      end
      m_stage <= '{a3: e_stage.a3, we: e_stage.we, tnew: tnew_dec(e_stage.tnew)};
      w_a3    <= m_stage.a3;
      w_we    <= m_stage.we;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .is_div (hif.D_md_div),
    .busy   (md_busy)
  );

  assign hif.stall    = stall;
  assign hif.md_busy  = md_busy;
  assign hif.D_fwd_rs = d_fwd_sel(e_stage, m_stage, hif.D_rs);
  assign hif.D_fwd_rt = d_fwd_sel(e_stage, m_stage, hif.D_rt);
  assign hif.E_fwd_rs = e_fwd_sel(m_stage, w_a3, w_we, e_rs);
  assign hif.E_fwd_rt = e_fwd_sel(m_stage, w_a3, w_we, e_rt);

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scenario bench for hazard_scheduler: expected outputs queued per cycle and compared.
module tb_hazard_scheduler;

  logic clk;
  logic reset;
  hazard_scheduler_if hif ();

  hazard_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       req;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tus;
    logic [1:0] tut;
    logic [4:0] a3;
    logic       we;
    logic [1:0] tnew;
    logic       mds;
    logic       mdd;
    logic       mdu;
  } din_t;

  logic [9:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic din_t ins(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] tus, input logic [1:0] tut,
                               input logic [4:0] a3, input logic we, input logic [1:0] tnew);
    din_t d;
    d.rst = 1'b1; d.req = 1'b0;
    d.rs = rs; d.rt = rt; d.tus = tus; d.tut = tut;
    d.a3 = a3; d.we = we; d.tnew = tnew;
    d.mds = 1'b0; d.mdd = 1'b0; d.mdu = 1'b0;
    return d;
  endfunction

  function automatic din_t nop();
    return ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
  endfunction

  // {stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, md_busy}
  function automatic logic [9:0] ex(input logic st, input logic [1:0] dfs, input logic [1:0] dft,
                                    input logic [1:0] efs, input logic [1:0] eft, input logic bz);
    return {st, dfs, dft, efs, eft, bz};
  endfunction

  task automatic apply(input din_t d);
    reset          = d.rst;
    hif.req        = d.req;
    hif.D_rs       = d.rs;
    hif.D_rt       = d.rt;
    hif.D_Tuse_rs  = d.tus;
    hif.D_Tuse_rt  = d.tut;
    hif.D_A3       = d.a3;
    hif.D_RegWrite = d.we;
    hif.D_Tnew     = d.tnew;
    hif.D_md_start = d.mds;
    hif.D_md_div   = d.mdd;
    hif.D_md_use   = d.mdu;
  endtask

  task automatic step(input string nm, input din_t d, input logic [9:0] e);
    logic [9:0] got;
    logic [9:0] want;
    @(negedge clk);
    apply(d);
    exp_q.push_back(e);
    #2;
    got  = {hif.stall, hif.D_fwd_rs, hif.D_fwd_rt, hif.E_fwd_rs, hif.E_fwd_rt, hif.md_busy};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: {stall,dfs,dft,efs,eft,busy} got %b expected %b", nm, got, want);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      apply(nop());
    end
  endtask

  task automatic test_reset();
    din_t z;
    z = ins(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    z.rst = 1'b0;
    step("reset_held", z, ex(0, 0, 0, 0, 0, 0));
    z.rst = 1'b1;
    step("reset_released", z, ex(0, 0, 0, 0, 0, 0));
    step("reset_idle", z, ex(0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_load_use();
    din_t add;
    add = ins(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 1'b1, 2'd1);
    step("lu_lw", ins(5'd2, 5'd0, 2'd1, 2'd3, 5'd1, 1'b1, 2'd2), ex(0, 0, 0, 0, 0, 0));
    step("lu_stall", add, ex(1, 0, 0, 0, 0, 0));
    step("lu_release", add, ex(0, 0, 0, 0, 0, 0));
    step("lu_e_fwd_w", nop(), ex(0, 0, 0, 2, 0, 0));
    step("lu_after", nop(), ex(0, 0, 0, 0, 0, 0));
    idle(3);
  endtask

  task automatic test_branch_alu();
    din_t beq;
    beq = ins(5'd4, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    step("br_addu", ins(5'd5, 5'd6, 2'd1, 2'd1, 5'd4, 1'b1, 2'd1), ex(0, 0, 0, 0, 0, 0));
    step("br_stall", beq, ex(1, 0, 0, 0, 0, 0));
    step("br_fwd_m", beq, ex(0, 2, 0, 0, 0, 0));
    step("br_e_fwd_w", nop(), ex(0, 0, 0, 2, 0, 0));
    idle(3);
  endtask

  task automatic test_forward_chain();
    step("ch_prod", ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 1'b1, 2'd0), ex(0, 0, 0, 0, 0, 0));
    step("ch_d_fwd_e", ins(5'd8, 5'd7, 2'd1, 2'd1, 5'd0, 1'b0, 2'd0), ex(0, 0, 1, 0, 0, 0));
    step("ch_e_fwd_m", nop(), ex(0, 0, 0, 0, 1, 0));
    idle(3);
    step("sh_p1", ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 1'b1, 2'd0), ex(0, 0, 0, 0, 0, 0));
    step("sh_p2", ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 1'b1, 2'd2), ex(0, 0, 0, 0, 0, 0));
    step("sh_shadow", ins(5'd9, 5'd9, 2'd2, 2'd2, 5'd0, 1'b0, 2'd0), ex(0, 0, 0, 0, 0, 0));
    idle(3);
  endtask

  task automatic test_zero_reg();
    step("z_lw0", ins(5'd0, 5'd0, 2'd1, 2'd3, 5'd0, 1'b1, 2'd2), ex(0, 0, 0, 0, 0, 0));
    step("z_add", ins(5'd0, 5'd0, 2'd1, 2'd1, 5'd2, 1'b1, 2'd1), ex(0, 0, 0, 0, 0, 0));
    step("z_e", nop(), ex(0, 0, 0, 0, 0, 0));
    step("z_m", nop(), ex(0, 0, 0, 0, 0, 0));
    idle(3);
  endtask

  task automatic test_mdu(input logic is_div, input int cycles);
    din_t st;
    din_t mf;
    st = nop(); st.mds = 1'b1; st.mdd = is_div;
    mf = ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 1'b1, 2'd1); mf.mdu = 1'b1;
    step(is_div ? "div_issue" : "mult_issue", st, ex(0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= cycles; i++)
      step(is_div ? "div_busy_stall" : "mult_busy_stall", mf, ex(1, 0, 0, 0, 0, 1));
    step(is_div ? "div_release" : "mult_release", mf, ex(0, 0, 0, 0, 0, 0));
    idle(3);
  endtask

  task automatic test_flush();
    din_t st;
    din_t add;
    st  = nop(); st.mds = 1'b1;
    add = ins(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 1'b1, 2'd1);
    step("fl_mult", st, ex(0, 0, 0, 0, 0, 0));
    step("fl_lw", ins(5'd2, 5'd0, 2'd1, 2'd3, 5'd1, 1'b1, 2'd2), ex(0, 0, 0, 0, 0, 1));
    add.req = 1'b1;
    step("fl_stall_req", add, ex(1, 0, 0, 0, 0, 1));
    add.req = 1'b0;
    step("fl_cleared", add, ex(0, 0, 0, 0, 0, 1));
    step("fl_no_w_fwd", nop(), ex(0, 0, 0, 0, 0, 1));
    step("fl_md_count", nop(), ex(0, 0, 0, 0, 0, 1));
    step("fl_md_done", nop(), ex(0, 0, 0, 0, 0, 0));
    st.req = 1'b1;
    step("fl_req_mult", st, ex(0, 0, 0, 0, 0, 0));
    step("fl_req_no_load", nop(), ex(0, 0, 0, 0, 0, 0));
    idle(3);
  endtask

  task automatic test_reset_mid();
    din_t st;
    din_t use_i;
    st    = nop(); st.mds = 1'b1;
    use_i = ins(5'd1, 5'd4, 2'd0, 2'd0, 5'd5, 1'b1, 2'd1);
    step("rm_mult", st, ex(0, 0, 0, 0, 0, 0));
    step("rm_lw", ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 1'b1, 2'd2), ex(0, 0, 0, 0, 0, 1));
    step("rm_addu", ins(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 1'b1, 2'd1), ex(0, 0, 0, 0, 0, 1));
    use_i.rst = 1'b0;
    step("rm_in_reset", use_i, ex(1, 0, 0, 0, 0, 1));
    use_i.rst = 1'b1;
    step("rm_after_reset", use_i, ex(0, 0, 0, 0, 0, 0));
    idle(3);
  endtask

  initial begin
    din_t z;
    z = ins(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    z.rst = 1'b0;
    apply(z);
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_branch_alu();
    test_forward_chain();
    test_zero_reg();
    test_mdu(1'b0, 5);
    test_mdu(1'b1, 10);
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
